neg_share_arbiter: RTL and testbench

Round-robin arbiter sharing one registered two's-complement negation stage among N requesting processing elements of the LU-factorization array. Each cycle it grants at most one requester, computes z = -x (mod 2^SZ), and presents x, z, and the requester index on a single registered output port with valid/ready backpressure. It sits between the elimination-row cells that need a negated pivot/multiplier and the downstream update cells.

---
 rtl/neg_share_arbiter.sv | 101 ++++++++++
 tb/tb_neg_share_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/neg_share_arbiter.sv
// Round-robin arbiter in front of one shared, registered two's-complement negation stage.
// Grants one requester per cycle and presents x, -x and the requester index with valid/ready.
module neg_share_arbiter #(
  parameter int unsigned SZ  = 8,
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned CW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*SZ-1:0]   x_in,
  output logic [N-1:0]      gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDW-1:0]    out_id,
  output logic [SZ-1:0]     x_out,
  output logic [SZ-1:0]     z_out,
  output logic [CW-1:0]     op_count
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gntIdx;
  logic [IDW-1:0] nextPtr;
  logic [IDW:0]   cand;
  logic           found;
  logic           acc;
  logic           xfer;
  logic [SZ-1:0]  selX;
  logic [SZ-1:0]  negX;

  assign acc = !out_valid || out_ready;

  // Circular scan starting at ptr; cand is one bit wider so ptr+k never aliases before the wrap.
  always_comb begin
    found  = 1'b0;
    gntIdx = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (cand == (IDW+1)'(i))) begin
          found  = 1'b1;
          gntIdx = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && acc && !rst) begin
      for (int i = 0; i < N; i++) begin
        gnt[i] = (gntIdx == IDW'(i));
      end
    end
  end

  assign xfer = |gnt;

  always_comb begin
    selX = '0;
    for (int i = 0; i < N; i++) begin
      if (gntIdx == IDW'(i)) begin
        selX = x_in[i*SZ +: SZ];
      end
    end
  end

  assign negX    = (~selX) + SZ'(1);
  assign nextPtr = (gntIdx == IDW'(N-1)) ? '0 : gntIdx + IDW'(1);

  // Output stage, pointer and accepted-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      x_out     <= '0;
      z_out     <= '0;
      op_count  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        op_count <= op_count + CW'(1);
      end
      if (xfer) begin
        ptr       <= nextPtr;
        x_out     <= selX;
        z_out     <= negX;
        out_id    <= gntIdx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neg_share_arbiter.sv
// Directed plus randomized bench for neg_share_arbiter against a cycle-level reference model.
module tb_neg_share_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  x_in;
  logic [3:0]   gnt;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_id;
  logic [7:0]   x_out;
  logic [7:0]   z_out;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mPtr = 0;
  int mValid = 0;
  int mId = 0;
  int mX = 0;
  int mZ = 0;
  int mCnt = 0;

  neg_share_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .x_out(x_out), .z_out(z_out), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setX(input int a, input int b, input int c, input int d);
    x_in = {8'(d), 8'(c), 8'(b), 8'(a)};
  endtask

  // One clock: check the combinational grant, advance the model, then check registered outputs.
  task automatic step(input bit r, input logic [3:0] rq, input bit rdy);
    int gi;
    int xs;
    logic [3:0] eg;
    rst = r;
    req = rq;
    out_ready = rdy;
    #1;
    gi = -1;
    eg = '0;
    if (!r && !(mValid == 1 && !rdy)) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && rq[(mPtr + k) % N]) gi = (mPtr + k) % N;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (r) begin
      mPtr = 0; mValid = 0; mId = 0; mX = 0; mZ = 0; mCnt = 0;
    end else begin
      if (mValid == 1 && rdy) mCnt = (mCnt + 1) % 65536;
      if (gi >= 0) begin
        xs = int'((x_in >> (gi * 8)) & 32'hFF);
        mX = xs;
        mZ = (256 - xs) % 256;
        mId = gi;
        mValid = 1;
        mPtr = (gi + 1) % N;
      end else if (rdy) begin
        mValid = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(mValid));
    chk("out_id", 32'(out_id), 32'(mId));
    chk("x_out", 32'(x_out), 32'(mX));
    chk("z_out", 32'(z_out), 32'(mZ));
    chk("op_count", 32'(op_count), 32'(mCnt));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    x_in = '0;
    @(posedge clk);
    #1;

    // Reset holds grant low even with every requester asserting.
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);

    // Fairness: four requesters, operands 1..4, eight grants then a drain cycle.
    setX(1, 2, 3, 4);
    for (int c = 0; c < 8; c++) step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    chk("fair_op_count", 32'(op_count), 32'd8);

    // Arithmetic corners through requester 0.
    setX(8'h00, 0, 0, 0); step(1'b0, 4'b0001, 1'b1);
    chk("neg_00", 32'(z_out), 32'h00);
    setX(8'h80, 0, 0, 0); step(1'b0, 4'b0001, 1'b1);
    chk("neg_80", 32'(z_out), 32'h80);
    setX(8'h7F, 0, 0, 0); step(1'b0, 4'b0001, 1'b1);
    chk("neg_7f", 32'(z_out), 32'h81);
    setX(8'hFF, 0, 0, 0); step(1'b0, 4'b0001, 1'b1);
    chk("neg_ff", 32'(z_out), 32'h01);
    setX(8'h01, 0, 0, 0); step(1'b0, 4'b0001, 1'b1);
    chk("neg_01", 32'(z_out), 32'hFF);
    step(1'b0, 4'b0000, 1'b1);

    // Backpressure: id 1 result 0x05/0xFB stalls while id 2 waits.
    setX(0, 5, 9, 0);
    step(1'b0, 4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0110, 1'b0);
    chk("bp_hold_z", 32'(z_out), 32'hFB);
    step(1'b0, 4'b0110, 1'b1);
    chk("bp_next_id", 32'(out_id), 32'd2);
    step(1'b0, 4'b0000, 1'b1);

    // Pointer wrap and skip: ptr moves to 3, then 0101 grants 0 then 2.
    setX(7, 0, 6, 0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0101, 1'b1);
    chk("wrap_id0", 32'(out_id), 32'd0);
    step(1'b0, 4'b0101, 1'b1);
    chk("wrap_id2", 32'(out_id), 32'd2);
    step(1'b0, 4'b0000, 1'b1);

    // Mid-stream reset with a stalled result, then first grant restarts at 0.
    setX(3, 4, 5, 6);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b1111, 1'b1);
    chk("mrst_first_id", 32'(out_id), 32'd0);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      setX(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      step(($urandom_range(0, 60) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
